// File: rtl/fpu_add_arbiter_pkg.sv
// rtl/fpu_add_arbiter_pkg.sv - shared types and constants for the fpu adder arbiter
package fpu_add_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_e;

  localparam logic [31:0] QNAN = 32'h7FFF_FFFF;

  typedef struct packed {
    logic [31:0] z;
    logic        invalid;
    logic        overflow;
    logic        timeout;
  } result_t;

endpackage

// File: rtl/fpu_add_arbiter_rr_pick.sv
// rtl/fpu_add_arbiter_rr_pick.sv - combinational round-robin selector
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             any
);

  int               idx;
  logic [N_REQ-1:0] rot;

  // Scan cyclically from ptr; the first set bit wins.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    rot   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      rot = req >> idx;
      if (!any && rot[0]) begin
        any   = 1'b1;
        grant = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fpu_add_arbiter.sv
// rtl/fpu_add_arbiter.sv - round-robin sharing of one fp adder path among N requesters
module fpu_add_arbiter
  import fpu_add_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  logic [32*N_REQ-1:0]  req_x_i,
  input  logic [32*N_REQ-1:0]  req_y_i,
  output logic [N_REQ-1:0]     req_ready_o,
  output logic [N_REQ-1:0]     resp_valid_o,
  output logic [31:0]          resp_z_o,
  output logic                 resp_invalid_o,
  output logic                 resp_overflow_o,
  output logic                 resp_timeout_o,
  output logic                 add_valid_o,
  output logic [31:0]          add_x_o,
  output logic [31:0]          add_y_o,
  input  logic                 add_valid_i,
  input  logic [31:0]          add_z_i,
  input  logic                 add_invalid_i,
  input  logic                 add_overflow_i,
  output logic                 busy_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic [31:0]         x_q, x_d, y_q, y_d;
  result_t             res_q, res_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [N_REQ-1:0]    grant_oh;
  logic [32*N_REQ-1:0] x_sh, y_sh;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (req_valid_i),
    .ptr   (ptr_q),
    .grant (pick_idx),
    .any   (pick_any)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    x_sh    = req_x_i >> (32 * int'(pick_idx));
    y_sh    = req_y_i >> (32 * int'(pick_idx));
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          x_d     = x_sh[31:0];
          y_d     = y_sh[31:0];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // A real result beats watchdog expiry in the same cycle.
        if (add_valid_i) begin
          res_d   = '{z: add_z_i, invalid: add_invalid_i, overflow: add_overflow_i, timeout: 1'b0};
          state_d = RESPOND;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          res_d   = '{z: QNAN, invalid: 1'b0, overflow: 1'b0, timeout: 1'b1};
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        ptr_d   = (int'(grant_q) == N_REQ - 1) ? '0 : grant_q + IDX_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_oh        = N_REQ'(1) << grant_q;
  assign req_ready_o     = (state_q == ISSUE) ? grant_oh : '0;
  assign add_valid_o     = (state_q == ISSUE);
  assign add_x_o         = x_q;
  assign add_y_o         = y_q;
  assign resp_valid_o    = (state_q == RESPOND) ? grant_oh : '0;
  assign resp_z_o        = (state_q == RESPOND) ? res_q.z : 32'h0;
  assign resp_invalid_o  = (state_q == RESPOND) && res_q.invalid;
  assign resp_overflow_o = (state_q == RESPOND) && res_q.overflow;
  assign resp_timeout_o  = (state_q == RESPOND) && res_q.timeout;
  assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// tb/tb_fpu_add_arbiter.sv - directed self-checking bench for fpu_add_arbiter
module tb_fpu_add_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [3:0]   req_valid_i;
  logic [127:0] req_x_i;
  logic [127:0] req_y_i;
  logic [3:0]   req_ready_o;
  logic [3:0]   resp_valid_o;
  logic [31:0]  resp_z_o;
  logic         resp_invalid_o;
  logic         resp_overflow_o;
  logic         resp_timeout_o;
  logic         add_valid_o;
  logic [31:0]  add_x_o;
  logic [31:0]  add_y_o;
  logic         add_valid_i;
  logic [31:0]  add_z_i;
  logic         add_invalid_i;
  logic         add_overflow_i;
  logic         busy_o;

  int checks = 0;
  int errors = 0;

  fpu_add_arbiter #(.N_REQ(4), .TIMEOUT(16)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid_i),
    .req_x_i         (req_x_i),
    .req_y_i         (req_y_i),
    .req_ready_o     (req_ready_o),
    .resp_valid_o    (resp_valid_o),
    .resp_z_o        (resp_z_o),
    .resp_invalid_o  (resp_invalid_o),
    .resp_overflow_o (resp_overflow_o),
    .resp_timeout_o  (resp_timeout_o),
    .add_valid_o     (add_valid_o),
    .add_x_o         (add_x_o),
    .add_y_o         (add_y_o),
    .add_valid_i     (add_valid_i),
    .add_z_i         (add_z_i),
    .add_invalid_i   (add_invalid_i),
    .add_overflow_i  (add_overflow_i),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni         = 1'b0;
    req_valid_i    = '0;
    req_x_i        = '0;
    req_y_i        = '0;
    add_valid_i    = 1'b0;
    add_z_i        = '0;
    add_invalid_i  = 1'b0;
    add_overflow_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req_x_i[32*k +: 32] = 32'h1000_0000 + k;
      req_y_i[32*k +: 32] = 32'h2000_0000 + k;
    end
    #1;
    check("rst_busy", {31'b0, busy_o}, 32'h0);
    check("rst_ready", {28'b0, req_ready_o}, 32'h0);
    check("rst_resp", {28'b0, resp_valid_o}, 32'h0);
    check("rst_addx", add_x_o, 32'h0);
    check("rst_addv", {31'b0, add_valid_o}, 32'h0);
    step();
    rst_ni = 1'b1;

    // Single request from requester 2, adder latency 4
    req_x_i[64 +: 32] = 32'h3F80_0000;
    req_y_i[64 +: 32] = 32'h4000_0000;
    req_valid_i = 4'b0100;
    step();
    check("t1_ready", {28'b0, req_ready_o}, 32'h4);
    check("t1_addv", {31'b0, add_valid_o}, 32'h1);
    check("t1_addx", add_x_o, 32'h3F80_0000);
    check("t1_addy", add_y_o, 32'h4000_0000);
    req_valid_i = '0;
    repeat (3) begin
      step();
      check("t1_noresp", {28'b0, resp_valid_o}, 32'h0);
      check("t1_noready", {28'b0, req_ready_o}, 32'h0);
    end
    step();
    add_valid_i = 1'b1;
    add_z_i     = 32'h4040_0000;
    step();
    add_valid_i = 1'b0;
    check("t1_resp", {28'b0, resp_valid_o}, 32'h4);
    check("t1_z", resp_z_o, 32'h4040_0000);
    check("t1_flags", {29'b0, resp_invalid_o, resp_overflow_o, resp_timeout_o}, 32'h0);
    step();
    check("t1_idle", {31'b0, busy_o}, 32'h0);
    check("t1_zclr", resp_z_o, 32'h0);
    check("t1_xhold", add_x_o, 32'h3F80_0000);

    // Fairness: everyone requests continuously
    do_reset();
    req_x_i[64 +: 32] = 32'h1000_0002;
    req_y_i[64 +: 32] = 32'h2000_0002;
    req_valid_i = 4'b1111;
    for (int op = 0; op < 8; op++) begin
      step();
      check("fair_ready", {28'b0, req_ready_o}, 32'h1 << (op % 4));
      check("fair_addx", add_x_o, 32'h1000_0000 + (op % 4));
      step();
      check("fair_pulse", {28'b0, req_ready_o}, 32'h0);
      add_valid_i = 1'b1;
      add_z_i     = 32'hA000_0000 + op;
      step();
      add_valid_i = 1'b0;
      check("fair_resp", {28'b0, resp_valid_o}, 32'h1 << (op % 4));
      check("fair_z", resp_z_o, 32'hA000_0000 + op);
      step();
    end
    req_valid_i = '0;

    // Watchdog expiry: adder never answers
    do_reset();
    req_valid_i = 4'b0010;
    step();
    check("to_ready", {28'b0, req_ready_o}, 32'h2);
    req_valid_i = '0;
    repeat (16) begin
      step();
      check("to_wait", {28'b0, resp_valid_o}, 32'h0);
    end
    step();
    check("to_resp", {28'b0, resp_valid_o}, 32'h2);
    check("to_z", resp_z_o, 32'h7FFF_FFFF);
    check("to_flags", {29'b0, resp_invalid_o, resp_overflow_o, resp_timeout_o}, 32'h1);
    step();
    check("to_idle", {31'b0, busy_o}, 32'h0);

    // Tie: result arrives on the expiry cycle; pointer is now 2
    req_valid_i = 4'b1000;
    step();
    check("tie_ready", {28'b0, req_ready_o}, 32'h8);
    req_valid_i = '0;
    repeat (16) step();
    add_valid_i = 1'b1;
    add_z_i     = 32'h1234_5678;
    step();
    add_valid_i = 1'b0;
    check("tie_resp", {28'b0, resp_valid_o}, 32'h8);
    check("tie_z", resp_z_o, 32'h1234_5678);
    check("tie_timeout", {31'b0, resp_timeout_o}, 32'h0);
    step();

    // Invalid and overflow flags pass through
    req_valid_i = 4'b0001;
    step();
    check("flg_ready", {28'b0, req_ready_o}, 32'h1);
    req_valid_i = '0;
    step();
    add_valid_i    = 1'b1;
    add_z_i        = 32'h7FC0_0000;
    add_invalid_i  = 1'b1;
    add_overflow_i = 1'b1;
    step();
    add_valid_i    = 1'b0;
    add_invalid_i  = 1'b0;
    add_overflow_i = 1'b0;
    check("flg_resp", {28'b0, resp_valid_o}, 32'h1);
    check("flg_z", resp_z_o, 32'h7FC0_0000);
    check("flg_flags", {29'b0, resp_invalid_o, resp_overflow_o, resp_timeout_o}, 32'h6);
    step();

    // Stray result pulse in IDLE
    add_valid_i = 1'b1;
    add_z_i     = 32'hDEAD_BEEF;
    step();
    add_valid_i = 1'b0;
    check("stray_busy", {31'b0, busy_o}, 32'h0);
    check("stray_resp", {28'b0, resp_valid_o}, 32'h0);
    step();
    check("stray_resp2", {28'b0, resp_valid_o}, 32'h0);
    check("stray_z", resp_z_o, 32'h0);

    // Reset two cycles into WAIT; the late result must be dropped
    req_valid_i = 4'b0100;
    step();
    check("rw_ready", {28'b0, req_ready_o}, 32'h4);
    req_valid_i = '0;
    step();
    step();
    check("rw_busy", {31'b0, busy_o}, 32'h1);
    rst_ni = 1'b0;
    #1;
    check("rw_busy0", {31'b0, busy_o}, 32'h0);
    check("rw_addx0", add_x_o, 32'h0);
    check("rw_addy0", add_y_o, 32'h0);
    check("rw_resp0", {28'b0, resp_valid_o}, 32'h0);
    step();
    rst_ni = 1'b1;
    step();
    add_valid_i = 1'b1;
    add_z_i     = 32'h5555_5555;
    step();
    add_valid_i = 1'b0;
    check("rw_noresp", {28'b0, resp_valid_o}, 32'h0);
    check("rw_idle", {31'b0, busy_o}, 32'h0);
    req_valid_i = 4'b1111;
    step();
    check("rw_first", {28'b0, req_ready_o}, 32'h1);
    req_valid_i = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_add_arbiter.md
Name: fpu_add_arbiter

Overview:
- Shares one floating-point adder pipeline between N requesters. Arbitration is round-robin, and the block runs one operation at a time.
- Captures the winner's 32-bit operand pair and issues it to the operand-decomposition and adder path. It then waits for the adder's result pulse and returns the result to the winner as a one-cycle response.
- A watchdog counter bounds the wait so that a lost result cannot hang the block.

Parameters:
- N_REQ, 4: number of requesters (1..16).
- TIMEOUT, 16: maximum cycles spent in WAIT before the block forces a timeout response (2..255).

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  N_REQ  per-requester request; must be held until the matching req_ready_o is seen.
- req_x_i  in  32*N_REQ  flattened IEEE-754 single-precision x operands; requester k occupies bits [32k+31:32k].
- req_y_i  in  32*N_REQ  flattened y operands, same layout.
- req_ready_o  out  N_REQ  one-hot accept pulse.
- resp_valid_o  out  N_REQ  one-hot response pulse.
- resp_z_o  out  32  result, shared by all requesters.
- resp_invalid_o  out  1  invalid-operation flag.
- resp_overflow_o  out  1  overflow flag.
- resp_timeout_o  out  1  watchdog expired.
- add_valid_o  out  1  issue pulse to the adder path.
- add_x_o  out  32  registered x operand.
- add_y_o  out  32  registered y operand.
- add_valid_i  in  1  adder result pulse.
- add_z_i  in  32  adder result.
- add_invalid_i  in  1  adder invalid-operation flag.
- add_overflow_i  in  1  adder overflow flag.
- busy_o  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (asynchronous, rst_ni=0):
  - State goes to IDLE and the round-robin pointer goes to 0.
  - The grant index, operand registers, result registers and watchdog counter all go to 0.
  - Every output is 0.
  - Reset in any state aborts the operation with no response.
  - An add_valid_i arriving after reset is ignored.
- IDLE:
  - If any req_valid_i bit is set, register grant = the first set index at or after the pointer, searching cyclically.
  - Capture that requester's x and y into add_x_o and add_y_o, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - req_ready_o[grant]=1 and add_valid_o=1.
  - Clear the watchdog counter and go to WAIT.
- WAIT:
  - The counter increments every cycle.
  - If add_valid_i=1, register add_z_i, add_invalid_i and add_overflow_i, set timeout=0, and go to RESPOND.
  - Else, if the counter equals TIMEOUT-1, register z=32'h7FFFFFFF, invalid=0, overflow=0, timeout=1, and go to RESPOND.
  - If add_valid_i and expiry occur in the same cycle, add_valid_i wins.
- RESPOND (exactly 1 cycle):
  - resp_valid_o[grant]=1 and resp_z_o and the flags show the registered values.
  - Pointer becomes (grant+1) mod N_REQ.
  - Go to IDLE.
- Output hold rules:
  - resp_z_o and the flags are 0 outside RESPOND.
  - add_x_o and add_y_o hold their values until the next capture.
- Stray results: add_valid_i in IDLE, ISSUE or RESPOND is ignored.
- Responses have no backpressure.
- Latency:
  - Request seen in IDLE at cycle 0: ready and issue at cycle 1.
  - Adder result at cycle 1+L: response at cycle 2+L.
  - A back-to-back request from another requester is granted in the IDLE cycle after RESPOND.
- Fairness:
  - The pointer advances only after a response.
  - A continuously requesting client is served at least once every N_REQ operations.
- Width rules:
  - The counter is 8 bits; the grant index is $clog2(N_REQ) bits, minimum 1.
  - For N_REQ=1 the pointer is always 0.
- Protocol violation: if a requester drops valid after being granted in IDLE, the captured operands are still issued and the response is still returned.

Decomposition:
- Shared fpu package:
  - state enum (IDLE, ISSUE, WAIT, RESPOND).
  - QNAN constant 32'h7FFFFFFF.
  - Result struct {z, invalid, overflow, timeout}.
- One sub-module, rr_pick: combinational round-robin selector (req vector and pointer in; grant index and any-request flag out). Reused by other FPU arbiters.

Test Plan:
- Single request: requester 2 sends x=32'h3F800000, y=32'h40000000, adder model returns 32'h40400000 after 4 cycles. Expect ready[2] at cycle 1, resp_valid[2] at cycle 6 with z=32'h40400000 and all flags 0.
- Fairness: all 4 requesters held valid for 8 operations. Expect grant order 0,1,2,3,0,1,2,3, each ready pulse exactly one cycle.
- Timeout: adder model never responds, TIMEOUT=16. Expect resp_valid on the granted requester 17 cycles after ISSUE, with z=32'h7FFFFFFF and timeout=1.
- Tie: add_valid_i in the same cycle the counter expires. Expect the adder result is returned and timeout=0.
- Stray and flags:
  - add_valid_i pulsed in IDLE: expect no response and no state change.
  - Adder model returns invalid=1: expect resp_invalid=1.
- Reset mid-WAIT: deassert rst_ni 2 cycles after ISSUE. Expect all outputs 0 immediately and no response when the result pulse arrives later. After release, requester 0 is granted first.
